ysyx_22041207_mem_arbiter: RTL

- Arbitrates one shared memory-side port between three requesters: IF-stage read, MEM-stage read and MEM-stage write. The shared port uses the same request/ready + data-valid/data-ready handshake as the existing read switch.
- Sits between the pipeline fetch/memory stages and the AXI master bridge, and replaces the read-only switch.
- Uses fixed priority, MEM write > MEM read > IF read, with an aging override so that fetch cannot starve.

---
 rtl/ysyx_22041207_mem_arbiter_pkg.sv | 36 +++
 rtl/ysyx_22041207_age_counter.sv | 34 +++
 rtl/ysyx_22041207_mem_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_mem_arbiter_pkg
// Shared definitions for the three-way memory arbiter:
//   arb_state_e   - arbiter FSM states (IDLE, GNT_IF, GNT_MR, GNT_MW)
//   GID_*         - grant identifiers (numerically equal to the grant states)
//   pick_grant()  - priority decision taken in IDLE
// ---------------------------------------------------------------------------
package ysyx_22041207_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_MR = 2'd2,
      GNT_MW = 2'd3
   } arb_state_e;

   localparam logic [1:0] GID_NONE = 2'd0;
   localparam logic [1:0] GID_IF   = 2'd1;
   localparam logic [1:0] GID_MR   = 2'd2;
   localparam logic [1:0] GID_MW   = 2'd3;

   // Aged fetch first, then MEM write > MEM read > IF read.
   function automatic logic [1:0] pick_grant(input logic age_hit,
                                             input logic if_v,
                                             input logic mr_v,
                                             input logic mw_v);
      logic [1:0] gid;
      if (if_v && age_hit)  gid = GID_IF;
      else if (mw_v)        gid = GID_MW;
      else if (mr_v)        gid = GID_MR;
      else if (if_v)        gid = GID_IF;
      else                  gid = GID_NONE;
      return gid;
   endfunction

endpackage

// File: rtl/ysyx_22041207_age_counter.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_age_counter
// Saturating wait-cycle counter for the pending IF read.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one more waiting cycle (saturates at limit)
//   clr      : clear to zero (wins over inc)
//   limit    : saturation value; 0 disables hit
//   hit      : count has reached a non-zero limit
//   count    : current age
// ---------------------------------------------------------------------------
module ysyx_22041207_age_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic [WIDTH-1:0] limit,
   output logic             hit,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count < limit))
         count <= count + WIDTH'(1);
   end

   assign hit = (limit != '0) && (count == limit);

endmodule

// File: rtl/ysyx_22041207_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_mem_arbiter
// Arbitrates one shared memory port between IF read, MEM read and MEM write.
// Fixed priority MEM write > MEM read > IF read, with an aging override so a
// pending fetch wins once it has waited STARVE_LIMIT cycles.
//   clk, rst          : clock, asynchronous active-high reset
//   if_r_*            : IF read requester (request, address/size, read data)
//   mem_r_*           : MEM read requester (same signal set as if_r_*)
//   mem_w_*           : MEM write requester (request, addr/data/strb, done)
//   s_r_*             : shared read port toward the AXI bridge
//   s_w_*             : shared write port toward the AXI bridge
// All outputs are 0 while in IDLE; the granted requester is forwarded
// combinationally until its completion handshake (or an abort before
// acceptance).
// ---------------------------------------------------------------------------
module ysyx_22041207_mem_arbiter
   import ysyx_22041207_mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH   = 64,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned AGE_WIDTH    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   // IF read
   input  logic                    if_r_valid_i,
   output logic                    if_r_ready_o,
   input  logic [ADDR_WIDTH-1:0]   if_r_addr_i,
   input  logic [7:0]              if_r_size_i,
   output logic [DATA_WIDTH-1:0]   if_r_data_o,
   output logic                    if_r_data_valid_o,
   input  logic                    if_r_data_ready_i,
   // MEM read
   input  logic                    mem_r_valid_i,
   output logic                    mem_r_ready_o,
   input  logic [ADDR_WIDTH-1:0]   mem_r_addr_i,
   input  logic [7:0]              mem_r_size_i,
   output logic [DATA_WIDTH-1:0]   mem_r_data_o,
   output logic                    mem_r_data_valid_o,
   input  logic                    mem_r_data_ready_i,
   // MEM write
   input  logic                    mem_w_valid_i,
   output logic                    mem_w_ready_o,
   input  logic [ADDR_WIDTH-1:0]   mem_w_addr_i,
   input  logic [DATA_WIDTH-1:0]   mem_w_data_i,
   input  logic [DATA_WIDTH/8-1:0] mem_w_strb_i,
   output logic                    mem_w_done_o,
   input  logic                    mem_w_done_ready_i,
   // shared read port
   output logic                    s_r_valid_o,
   input  logic                    s_r_ready_i,
   output logic [ADDR_WIDTH-1:0]   s_r_addr_o,
   output logic [7:0]              s_r_size_o,
   input  logic [DATA_WIDTH-1:0]   s_r_data_i,
   input  logic                    s_r_data_valid_i,
   output logic                    s_r_data_ready_o,
   // shared write port
   output logic                    s_w_valid_o,
   input  logic                    s_w_ready_i,
   output logic [ADDR_WIDTH-1:0]   s_w_addr_o,
   output logic [DATA_WIDTH-1:0]   s_w_data_o,
   output logic [DATA_WIDTH/8-1:0] s_w_strb_o,
   input  logic                    s_w_done_i,
   output logic                    s_w_done_ready_o
);

   arb_state_e state, state_nxt;
   logic       accepted;
   logic       grant_valid, grant_hs, grant_done;
   logic       age_inc, age_clr, age_hit;
   logic [AGE_WIDTH-1:0] age_count;

   // ---------------- state register + accepted flag -----------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         accepted <= 1'b0;
      end else begin
         state    <= state_nxt;
         accepted <= (state_nxt == IDLE) ? 1'b0 : (accepted | grant_hs);
      end
   end

   // ---------------- next state + forwarding ------------------------------
   always_comb begin
      state_nxt          = state;
      grant_valid        = 1'b0;
      grant_hs           = 1'b0;
      grant_done         = 1'b0;
      if_r_ready_o       = 1'b0;
      if_r_data_o        = '0;
      if_r_data_valid_o  = 1'b0;
      mem_r_ready_o      = 1'b0;
      mem_r_data_o       = '0;
      mem_r_data_valid_o = 1'b0;
      mem_w_ready_o      = 1'b0;
      mem_w_done_o       = 1'b0;
      s_r_valid_o        = 1'b0;
      s_r_addr_o         = '0;
      s_r_size_o         = '0;
      s_r_data_ready_o   = 1'b0;
      s_w_valid_o        = 1'b0;
      s_w_addr_o         = '0;
      s_w_data_o         = '0;
      s_w_strb_o         = '0;
      s_w_done_ready_o   = 1'b0;

      unique case (state)
         IDLE: begin
            state_nxt = arb_state_e'(pick_grant(age_hit, if_r_valid_i,
                                                mem_r_valid_i, mem_w_valid_i));
         end
         GNT_IF: begin
            s_r_valid_o       = if_r_valid_i;
            s_r_addr_o        = if_r_addr_i;
            s_r_size_o        = if_r_size_i;
            s_r_data_ready_o  = if_r_data_ready_i;
            if_r_ready_o      = s_r_ready_i;
            if_r_data_o       = s_r_data_i;
            if_r_data_valid_o = s_r_data_valid_i;
            grant_valid       = if_r_valid_i;
            grant_hs          = if_r_valid_i && s_r_ready_i;
            grant_done        = s_r_data_valid_i && if_r_data_ready_i;
         end
         GNT_MR: begin
            s_r_valid_o        = mem_r_valid_i;
            s_r_addr_o         = mem_r_addr_i;
            s_r_size_o         = mem_r_size_i;
            s_r_data_ready_o   = mem_r_data_ready_i;
            mem_r_ready_o      = s_r_ready_i;
            mem_r_data_o       = s_r_data_i;
            mem_r_data_valid_o = s_r_data_valid_i;
            grant_valid        = mem_r_valid_i;
            grant_hs           = mem_r_valid_i && s_r_ready_i;
            grant_done         = s_r_data_valid_i && mem_r_data_ready_i;
         end
         GNT_MW: begin
            s_w_valid_o      = mem_w_valid_i;
            s_w_addr_o       = mem_w_addr_i;
            s_w_data_o       = mem_w_data_i;
            s_w_strb_o       = mem_w_strb_i;
            s_w_done_ready_o = mem_w_done_ready_i;
            mem_w_ready_o    = s_w_ready_i;
            mem_w_done_o     = s_w_done_i;
            grant_valid      = mem_w_valid_i;
            grant_hs         = mem_w_valid_i && s_w_ready_i;
            grant_done       = s_w_done_i && mem_w_done_ready_i;
         end
      endcase

      // Release on completion; abort only if the request was never accepted.
      if ((state != IDLE) && ((!accepted && !grant_valid) || grant_done))
         state_nxt = IDLE;
   end

   // ---------------- IF aging ---------------------------------------------
   assign age_inc = if_r_valid_i && (state != GNT_IF);
   assign age_clr = !if_r_valid_i || ((state == IDLE) && (state_nxt == GNT_IF));

   ysyx_22041207_age_counter #(
      .WIDTH (AGE_WIDTH)
   ) u_age (
      .clk   (clk),
      .rst   (rst),
      .inc   (age_inc),
      .clr   (age_clr),
      .limit (AGE_WIDTH'(STARVE_LIMIT)),
      .hit   (age_hit),
      .count (age_count)
   );

endmodule
